// File: rtl/mips_pkg.sv
// Shared MIPS R2000 encodings for decode and execute.
// ALU classes, R-type funct codes and mult/div defaults.
package mips_pkg;

  localparam int unsigned MD_CYCLES_DEF = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  function automatic logic is_md_funct(
    input logic [5:0] f
  );
    return (f == F_MULT) || (f == F_MULTU) ||
           (f == F_DIV)  || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, MEM/WB forwarding and EX/MEM outputs
// of the execute stage, bundled for port connection.
interface execute_stage_if;
  logic [5:0]  ex;
  logic [2:0]  m;
  logic [1:0]  wb;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic        flush_ex;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data_reg;
  logic [2:0]  m_mem;
  logic [1:0]  wb_mem;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dst_reg;
  logic        overflow;
  logic        stall_ex;

  modport master (
    output ex, m, wb, rs, rt, rd, imm,
    output data_1, data_2, flush_ex,
    output reg_write, write_register,
    output write_data_reg,
    input  m_mem, wb_mem, alu_result,
    input  store_data, dst_reg,
    input  overflow, stall_ex
  );

  modport slave (
    input  ex, m, wb, rs, rt, rd, imm,
    input  data_1, data_2, flush_ex,
    input  reg_write, write_register,
    input  write_data_reg,
    output m_mem, wb_mem, alu_result,
    output store_data, dst_reg,
    output overflow, stall_ex
  );
endinterface

// File: rtl/execute_mult_div.sv
// Iterative HI/LO unit: shift-add multiply and
// restoring divide on magnitudes, signs fixed at the end.
module execute_mult_div
  import mips_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int unsigned CW = $clog2(MD_CYCLES + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] count_q;
  logic [31:0]   acc_q, wrk_q, opd_q;
  logic [31:0]   acc_d, wrk_d;
  logic          div_q, negq_q, negr_q, zero_q;
  logic          last;
  logic [32:0]   rem33, dif33, sum33;
  logic [63:0]   prod;
  logic [31:0]   quot, rem, abs_a, abs_b;

  assign abs_a = (is_signed && a[31]) ? -a : a;
  assign abs_b = (is_signed && b[31]) ? -b : b;
  assign busy  = state_q == MD_BUSY;
  assign last  = busy && (count_q == CW'(1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MD_IDLE;
    else      state_q <= state_d;
  end

  // next state: start from idle, finish on last step
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start) state_d = MD_BUSY;
      MD_BUSY: if (last)  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // one multiply or divide iteration
  always_comb begin
    acc_d = acc_q;
    wrk_d = wrk_q;
    rem33 = {acc_q, wrk_q[31]};
    dif33 = rem33 - {1'b0, opd_q};
    sum33 = {1'b0, acc_q} +
            (wrk_q[0] ? {1'b0, opd_q} : 33'd0);
    if (div_q) begin
      if (rem33 >= {1'b0, opd_q}) begin
        acc_d = dif33[31:0];
        wrk_d = {wrk_q[30:0], 1'b1};
      end else begin
        acc_d = rem33[31:0];
        wrk_d = {wrk_q[30:0], 1'b0};
      end
    end else begin
      acc_d = sum33[32:1];
      wrk_d = {sum33[0], wrk_q[31:1]};
    end
  end

  // sign fix-up of the final iteration
  always_comb begin
    prod = {acc_d, wrk_d};
    if (negq_q) prod = -prod;
    quot = negq_q ? -wrk_d : wrk_d;
    if (zero_q) quot = '1;
    rem  = negr_q ? -acc_d : acc_d;
  end

  // operand capture, iteration and HI/LO write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (!busy) begin
      if (start) begin
        acc_q   <= '0;
        wrk_q   <= abs_a;
        opd_q   <= abs_b;
        div_q   <= is_div;
        negq_q  <= is_signed && (a[31] ^ b[31]);
        negr_q  <= is_signed && a[31];
        zero_q  <= is_div && (b == '0);
        count_q <= CW'(MD_CYCLES);
      end
    end else begin
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      count_q <= count_q - CW'(1);
      if (last) begin
        hi <= div_q ? rem  : prod[63:32];
        lo <= div_q ? quot : prod[31:0];
      end
    end
  end
endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding, ALU, HI/LO unit and
// the EX/MEM register, plus the front-end stall.
module execute_stage
  import mips_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  logic [3:0]  cls;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        is_r, is_md, is_mf;
  logic        md_busy, md_start, bubble;
  logic        fa_ex, fa_wb, fb_ex, fb_wb;
  logic [31:0] op_a, op_b, op2, hi, lo, res;
  logic [32:0] sum33, dif33;
  logic        ovf;

  assign cls   = bus.ex[4:1];
  assign funct = bus.imm[5:0];
  assign shamt = bus.imm[10:6];
  assign is_r  = cls == ALU_RTYPE;
  assign is_md = is_r && is_md_funct(funct);
  assign is_mf = is_r &&
                 (funct == F_MFHI || funct == F_MFLO);

  assign fa_ex = bus.wb_mem[1] && !bus.m_mem[1] &&
                 bus.rs != 5'd0 && bus.dst_reg == bus.rs;
  assign fa_wb = bus.reg_write && bus.rs != 5'd0 &&
                 bus.write_register == bus.rs;
  assign fb_ex = bus.wb_mem[1] && !bus.m_mem[1] &&
                 bus.rt != 5'd0 && bus.dst_reg == bus.rt;
  assign fb_wb = bus.reg_write && bus.rt != 5'd0 &&
                 bus.write_register == bus.rt;

  // operand muxes, EX/MEM ahead of MEM/WB
  always_comb begin
    op_a = bus.data_1;
    op_b = bus.data_2;
    if (fa_ex)      op_a = bus.alu_result;
    else if (fa_wb) op_a = bus.write_data_reg;
    if (fb_ex)      op_b = bus.alu_result;
    else if (fb_wb) op_b = bus.write_data_reg;
    op2 = bus.ex[0] ? bus.imm : op_b;
  end

  assign bus.stall_ex = md_busy && (is_md || is_mf);
  assign bubble   = bus.stall_ex || bus.flush_ex;
  assign md_start = is_md && !bus.flush_ex && !md_busy;

  execute_mult_div #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .is_div   (funct[1]),
    .is_signed(!funct[0]),
    .a        (op_a),
    .b        (op_b),
    .busy     (md_busy),
    .hi       (hi),
    .lo       (lo)
  );

  // ALU with signed overflow on ADD/SUB/ADDI
  always_comb begin
    res   = '0;
    ovf   = 1'b0;
    sum33 = {op_a[31], op_a} + {op2[31], op2};
    dif33 = {op_a[31], op_a} - {op2[31], op2};
    unique case (1'b1)
      cls == ALU_ADD: begin
        res = sum33[31:0];
        ovf = sum33[32] ^ sum33[31];
      end
      cls == ALU_SUB: res = dif33[31:0];
      cls == ALU_AND: res = op_a & op2;
      is_r: begin
        case (funct)
          F_ADD: begin
            res = sum33[31:0];
            ovf = sum33[32] ^ sum33[31];
          end
          F_ADDU: res = sum33[31:0];
          F_SUB: begin
            res = dif33[31:0];
            ovf = dif33[32] ^ dif33[31];
          end
          F_SUBU: res = dif33[31:0];
          F_AND:  res = op_a & op2;
          F_OR:   res = op_a | op2;
          F_XOR:  res = op_a ^ op2;
          F_NOR:  res = ~(op_a | op2);
          F_SLT:
            res = {31'd0, $signed(op_a) < $signed(op2)};
          F_SLTU: res = {31'd0, op_a < op2};
          F_SLL:  res = op2 << shamt;
          F_SRL:  res = op2 >> shamt;
          F_SRA:  res = $signed(op2) >>> shamt;
          F_MFHI: res = hi;
          F_MFLO: res = lo;
          default: res = '0;
        endcase
      end
      default: res = sum33[31:0];
    endcase
  end

  // EX/MEM register; stall or flush loads a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.m_mem      <= '0;
      bus.wb_mem     <= '0;
      bus.alu_result <= '0;
      bus.store_data <= '0;
      bus.dst_reg    <= '0;
      bus.overflow   <= 1'b0;
    end else if (bubble) begin
      bus.m_mem      <= '0;
      bus.wb_mem     <= '0;
      bus.alu_result <= '0;
      bus.store_data <= '0;
      bus.dst_reg    <= '0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.m_mem      <= bus.m;
      bus.wb_mem     <= ovf ? 2'b00 : bus.wb;
      bus.alu_result <= res;
      bus.store_data <= op_b;
      bus.dst_reg    <= bus.ex[5] ? bus.rd : bus.rt;
      bus.overflow   <= ovf;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed and random checks of execute_stage against
// an arithmetic reference model of the EX stage.
module tb_execute_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  execute_stage_if bus();

  execute_stage #(
    .MD_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_obs = 0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic [2:0]  e_m;
  logic [1:0]  e_wb;
  logic [31:0] e_alu, e_store;
  logic [4:0]  e_dst;
  logic        e_ovf;
  logic [31:0] r_hi, r_lo, p_hi, p_lo;
  int          left;

  logic [5:0] fl [20] = '{
    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR,
    F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_MULT,
    F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, 6'h3F
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_m = '0; e_wb = '0; e_alu = '0; e_store = '0;
    e_dst = '0; e_ovf = 1'b0;
    r_hi = '0; r_lo = '0; p_hi = '0; p_lo = '0;
    left = 0;
  endtask

  function automatic logic [31:0] fwd(
    input logic [4:0] s, input logic [31:0] dflt);
    if (s != 0 && e_wb[1] && !e_m[1] && e_dst == s)
      return e_alu;
    if (s != 0 && bus.reg_write && bus.write_register == s)
      return bus.write_data_reg;
    return dflt;
  endfunction

  function automatic logic [31:0] alu_ref(
    input logic [3:0] cls, input logic [5:0] fn,
    input logic [4:0] sh, input logic [31:0] a,
    input logic [31:0] b, output logic ovf);
    longint s, d;
    logic signed [31:0] sb;
    s = longint'($signed(a)) + longint'($signed(b));
    d = longint'($signed(a)) - longint'($signed(b));
    sb = b;
    ovf = 1'b0;
    if (cls == ALU_ADD) begin
      ovf = (s > MAXI) || (s < MINI);
      return a + b;
    end
    if (cls == ALU_SUB) return a - b;
    if (cls == ALU_AND) return a & b;
    if (cls != ALU_RTYPE) return a + b;
    case (fn)
      F_ADD: begin ovf = (s > MAXI) || (s < MINI); return a + b; end
      F_ADDU: return a + b;
      F_SUB: begin ovf = (d > MAXI) || (d < MINI); return a - b; end
      F_SUBU: return a - b;
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_XOR:  return a ^ b;
      F_NOR:  return ~(a | b);
      F_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      F_SLTU: return (a < b) ? 1 : 0;
      F_SLL:  return b << sh;
      F_SRL:  return b >> sh;
      F_SRA:  return sb >>> sh;
      F_MFHI: return r_hi;
      F_MFLO: return r_lo;
      default: return 0;
    endcase
  endfunction

  task automatic md_ref(input logic [5:0] fn,
                        input logic [31:0] a,
                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (fn == F_MULT || fn == F_MULTU) begin
      if (fn == F_MULT) p = 64'(sa * sb);
      else p = {32'd0, a} * {32'd0, b};
      p_hi = p[63:32];
      p_lo = p[31:0];
    end else if (b == 0) begin
      p_hi = a;
      p_lo = 32'hFFFF_FFFF;
    end else if (fn == F_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p_hi = 32'(r);
      p_lo = 32'(q);
    end else begin
      p_hi = a % b;
      p_lo = a / b;
    end
  endtask

  task automatic drive(input logic [5:0] ex,
                       input logic [2:0] m,
                       input logic [1:0] wb,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [31:0] imm,
                       input logic [31:0] d1,
                       input logic [31:0] d2,
                       input logic fl_ex);
    bus.ex = ex; bus.m = m; bus.wb = wb;
    bus.rs = rs; bus.rt = rt; bus.rd = rd;
    bus.imm = imm; bus.data_1 = d1; bus.data_2 = d2;
    bus.flush_ex = fl_ex;
  endtask

  task automatic rtype(input logic [5:0] fn,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [31:0] d1,
                       input logic [31:0] d2,
                       input logic [1:0] wb);
    drive({1'b1, ALU_RTYPE, 1'b0}, 3'b000, wb, rs, rt, rd,
          {26'd0, fn}, d1, d2, 1'b0);
  endtask

  task automatic chk_out();
    chk("m_mem", bus.m_mem, e_m);
    chk("wb_mem", bus.wb_mem, e_wb);
    chk("alu_result", bus.alu_result, e_alu);
    chk("store_data", bus.store_data, e_store);
    chk("dst_reg", bus.dst_reg, e_dst);
    chk("overflow", bus.overflow, e_ovf);
  endtask

  // One clock: entered and left 1 time unit after a rising edge.
  task automatic cyc();
    logic [31:0] a, b, op2, res;
    logic ovf, isr, md, mf, stl, bub;
    logic [5:0] fn;
    logic [2:0] n_m;
    logic [1:0] n_wb;
    logic [4:0] n_dst;
    #1;
    isr = bus.ex[4:1] == ALU_RTYPE;
    fn  = bus.imm[5:0];
    md  = isr && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    mf  = isr && (fn == F_MFHI || fn == F_MFLO);
    stl = (left > 0) && (md || mf);
    a   = fwd(bus.rs, bus.data_1);
    b   = fwd(bus.rt, bus.data_2);
    op2 = bus.ex[0] ? bus.imm : b;
    res = alu_ref(bus.ex[4:1], fn, bus.imm[10:6], a, op2, ovf);
    chk("stall_ex", bus.stall_ex, stl);
    if (bus.stall_ex === 1'b1) stall_obs++;
    bub   = stl || bus.flush_ex;
    n_m   = bus.m;
    n_wb  = ovf ? 2'b00 : bus.wb;
    n_dst = bus.ex[5] ? bus.rd : bus.rt;
    if (left > 0) begin
      left--;
      if (left == 0) begin r_hi = p_hi; r_lo = p_lo; end
    end else if (md && !bus.flush_ex) begin
      left = 32;
      md_ref(fn, a, b);
    end
    @(posedge clk);
    #1;
    if (bub) begin
      e_m = '0; e_wb = '0; e_alu = '0; e_store = '0;
      e_dst = '0; e_ovf = 1'b0;
    end else begin
      e_m = n_m; e_wb = n_wb; e_alu = res; e_store = b;
      e_dst = n_dst; e_ovf = ovf;
    end
    chk_out();
  endtask

  task automatic md_wait();
    for (int j = 0; j < 40 && left > 0; j++) cyc();
    cyc();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 200));
      2: return 32'h7FFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] rv;
    model_reset();
    bus.reg_write = 1'b0;
    bus.write_register = '0;
    bus.write_data_reg = '0;
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    #12;
    chk_out();
    chk("rst_stall", bus.stall_ex, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // ADD overflow
    rtype(F_ADD, 5'd1, 5'd2, 5'd3, 32'h7FFF_FFFF, 32'd1, 2'b10);
    cyc();
    chk("ovf_flag", bus.overflow, 1'b1);
    chk("ovf_wb", bus.wb_mem, 2'b00);
    chk("ovf_res", bus.alu_result, 32'h8000_0000);

    // forwarding priority and r0
    drive({1'b0, ALU_ADD, 1'b1}, 3'b000, 2'b10, 5'd1, 5'd5,
          5'd0, 32'd5, 32'd10, 32'd0, 1'b0);
    cyc();
    rtype(F_ADD, 5'd5, 5'd2, 5'd3, 32'd999, 32'd1, 2'b10);
    bus.reg_write = 1'b1;
    bus.write_register = 5'd5;
    bus.write_data_reg = 32'd77;
    cyc();
    chk("fwd_exmem", bus.alu_result, 32'd16);
    drive({1'b0, ALU_ADD, 1'b1}, 3'b000, 2'b10, 5'd1, 5'd0,
          5'd0, 32'd1, 32'd50, 32'd0, 1'b0);
    cyc();
    rtype(F_ADD, 5'd0, 5'd2, 5'd3, 32'd3, 32'd4, 2'b10);
    bus.write_register = 5'd0;
    cyc();
    chk("fwd_r0", bus.alu_result, 32'd7);
    bus.reg_write = 1'b0;

    // MULT then MFLO / MFHI
    rtype(F_MULT, 5'd1, 5'd2, 5'd0, -32'sd3, 32'd7, 2'b00);
    cyc();
    rtype(F_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    stall_obs = 0;
    md_wait();
    chk("stall_cycles", stall_obs, 32);
    chk("mflo_mult", bus.alu_result, 32'hFFFF_FFEB);
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    cyc();
    chk("mfhi_mult", bus.alu_result, 32'hFFFF_FFFF);

    // DIVU and divide by zero
    rtype(F_DIVU, 5'd1, 5'd2, 5'd0, 32'd100, 32'd7, 2'b00);
    cyc();
    rtype(F_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    md_wait();
    chk("divu_lo", bus.alu_result, 32'd14);
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    cyc();
    chk("divu_hi", bus.alu_result, 32'd2);
    rtype(F_DIV, 5'd1, 5'd2, 5'd0, 32'hFFFF_FF9C, 32'd0, 2'b00);
    cyc();
    rtype(F_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    md_wait();
    chk("div0_lo", bus.alu_result, 32'hFFFF_FFFF);
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    cyc();
    chk("div0_hi", bus.alu_result, 32'hFFFF_FF9C);

    // flush of ANDI and of MULT
    drive({1'b0, ALU_AND, 1'b1}, 3'b010, 2'b11, 5'd1, 5'd4,
          5'd0, 32'hFF, 32'h1234, 32'd0, 1'b1);
    cyc();
    chk("flush_m", bus.m_mem, 3'b000);
    chk("flush_wb", bus.wb_mem, 2'b00);
    rtype(F_MULT, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 2'b00);
    bus.flush_ex = 1'b1;
    cyc();
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    cyc();
    chk("flushed_mult_hi", bus.alu_result, 32'hFFFF_FF9C);

    // reset in the middle of a multiply
    rtype(F_MULT, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 2'b00);
    cyc();
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    repeat (10) cyc();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_out();
    chk("rst_mid_stall", bus.stall_ex, 1'b0);
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 2'b10);
    cyc();
    chk("mfhi_after_rst", bus.alu_result, 32'd0);

    // random instruction stream
    for (int i = 0; i < 150; i++) begin
      int k;
      logic [3:0] cls;
      logic [5:0] fn;
      k = $urandom_range(0, 7);
      rv = $urandom;
      fn = fl[$urandom_range(0, 19)];
      if (k < 4) cls = ALU_RTYPE;
      else if (k == 4) cls = ALU_ADD;
      else if (k == 5) cls = ALU_SUB;
      else if (k == 6) cls = ALU_AND;
      else cls = 4'($urandom_range(4, 15));
      drive({rv[31], cls, (cls == ALU_RTYPE) ? 1'b0 : rv[30]},
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            (cls == ALU_RTYPE) ? {rv[31:11], rv[10:6], fn}
                               : {16'd0, rv[15:0]},
            pick(), pick(), $urandom_range(0, 7) == 0);
      bus.reg_write = 1'($urandom_range(0, 1));
      bus.write_register = 5'($urandom_range(0, 3));
      bus.write_data_reg = pick();
      cyc();
      for (int j = 0; j < 40 && bus.stall_ex === 1'b1; j++)
        cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

EX stage of the 5-stage MIPS R2000 pipeline. It sits between the ID/EX register and the MEM stage, and contains:
- operand forwarding;
- the ALU;
- an iterative HI/LO multiply/divide unit;
- the EX/MEM pipeline register.

It consumes the ID/EX control (`ex`, `m`, `wb`) and operand fields, and produces registered results for MEM together with a stall request for the front end.

## Interface
Parameters:
- `MD_CYCLES`, 32: iterations per multiply/divide.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex`  in  6  ID/EX control: [5] reg_dst, [4:1] alu_class, [0] alu_src.
- `m`, `wb`  in  3, 2  ID/EX memory (branch/read/write) and writeback (reg_write/mem_to_reg) control.
- `rs`, `rt`, `rd`  in  5 each  ID/EX register numbers.
- `imm`, `data_1`, `data_2`  in  32 each  zero-extended immediate and register-file operands.
- `flush_ex`  in  1  squash the instruction currently in EX.
- `reg_write`, `write_register`, `write_data_reg`  in  1/5/32  MEM/WB writeback, used for forwarding.
- `m_mem`, `wb_mem`  out  3, 2  EX/MEM control.
- `alu_result`, `store_data`  out  32 each  EX/MEM result and forwarded rt value.
- `dst_reg`  out  5  EX/MEM destination.
- `overflow`  out  1  registered arithmetic-overflow exception.
- `stall_ex`  out  1  combinational request to freeze PC, IF/ID and ID/EX.

## Operation
- **Forwarding**, per operand (rs→A, rt→B):
  - Use EX/MEM `alu_result` if `wb_mem[1]` && `!m_mem[1]` && `dst_reg` == src && src != 0.
  - Otherwise use `write_data_reg` if `reg_write` && `write_register` == src && src != 0.
  - Otherwise use `data_1`/`data_2`.
  - EX/MEM has priority over MEM/WB.
- **Second ALU operand**: `imm` when `ex[0]`, otherwise forwarded B. `store_data` is always forwarded B.
- **alu_class**:
  - 0000: add (overflow-checked).
  - 0001: sub.
  - 0011: and.
  - 0010: R-type, decoded from `imm[5:0]` (funct) with `imm[10:6]` (shamt).
  - Others: add without overflow check.
- **R-type funct set**:
  - ALU: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA.
  - Multiply/divide: MULT, MULTU, DIV, DIVU, MFHI, MFLO.
  - Unknown funct → result 0.
- **Destination**: `dst_reg` = `ex[5]` ? `rd` : `rt`.
- **Overflow**: signed 33-bit check on ADD/SUB/ADDI. When set, the instruction's `wb_mem` is forced to 00 and `overflow` = 1 for one cycle.
- **Multiply/divide unit** (`execute_mult_div`). FSM states:
  - IDLE: a MULT*/DIV* in EX with no stall captures A and B and moves to BUSY with count = `MD_CYCLES`.
  - BUSY: one shift-add or restoring-divide step per cycle. When count reaches 0, HI/LO are written and the FSM returns to IDLE.
  - Signed operations take magnitudes and fix signs on completion.
  - Divide by zero: HI = A, LO = 32'hFFFF_FFFF. No trap.
- **Stall**: `stall_ex` = BUSY && (funct ∈ {MFHI, MFLO, MULT*, DIV*}) in EX with alu_class 0010.
  - While stalled, the EX/MEM register loads a bubble (control zeroed).
  - An MFHI/MFLO issued in the completion cycle's successor reads the new HI/LO.
- **Flush**: `flush_ex` loads a bubble into EX/MEM. A multiply/divide being issued in that cycle is not started. A multiply/divide already BUSY continues.

## Timing
- **Reset**: all outputs, HI, LO and count = 0; FSM = IDLE. Reset asserted mid-divide aborts the operation and leaves HI/LO = 0.
- **ALU latency**: one cycle. EX inputs sampled at edge n appear on EX/MEM outputs at edge n+1.
- **Multiply/divide latency**: issue at edge n; HI/LO valid after edge n+`MD_CYCLES`. `stall_ex` deasserts in the cycle after that edge.
- `stall_ex` and forwarding paths are combinational. EX/MEM outputs are registered.
- **Simultaneous events**:
  - stall and flush together → bubble.
  - Forwarding hits on both EX/MEM and MEM/WB → EX/MEM wins.

## Structure
- `mips_pkg` holds the funct codes, the alu_class encodings and the `MD_CYCLES` default. It is shared with decode.
- `execute_mult_div` is the single sub-module: FSM, counter, HI/LO and the iterative datapath.
- Forwarding, ALU and the EX/MEM register stay in `execute_stage`.

## Test plan
- **ADD overflow**: ADD with A=32'h7FFF_FFFF, B=1 → next cycle `overflow`=1, `wb_mem`=00, `alu_result`=32'h8000_0000.
- **Forwarding priority**: back-to-back dependent ADDI then ADD with MEM/WB also matching rs → A taken from EX/MEM. With rs=0 and any match → A = `data_1`.
- **MULT then MFLO**: MULT A=-3, B=7, then MFLO → `stall_ex` high for 32 cycles, bubbles on EX/MEM, then `alu_result`=32'hFFFF_FFEB. MFHI → 32'hFFFF_FFFF.
- **DIVU and divide by zero**: DIVU 100/7 → LO=14, HI=2. DIV by 0 → LO=32'hFFFF_FFFF, HI=A.
- **Flush**: `flush_ex` with ANDI in EX → `m_mem`, `wb_mem` = 0 next cycle. Flushed MULT never sets BUSY.
- **Reset mid-operation**: `rst` low during BUSY cycle 10 → all outputs 0 immediately, FSM IDLE. A following MFHI returns 0 without stall.
